uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte FIFO and launch sequencer between the memory-mapped UART peripheral (bus side, clocked on `sysclk`) and the `UART_Sender` bit serializer. The peripheral pushes bytes back-to-back without polling. The block pops one byte at a time, pulses `tx_en` only while the sender reports idle, and tracks each frame until the sender returns to idle. This lets software queue up to DEPTH bytes per TX interrupt instead of one.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `AW`, 4: log2(DEPTH); pointer width.

- `sysclk`  in  1  single clock for all state.
- `reset`  in  1  synchronous, active-low; sampled on `sysclk` rising edge.
- `wr_en`  in  1  push request, one byte per cycle high.
- `wr_data`  in  8  byte to push.
- `clr_ovf`  in  1  clears `overflow`.
- `tx_status`  in  1  from sender: 1 = idle, 0 = shifting a frame.
- `tx_data`  out  8  byte to sender; registered.
- `tx_en`  out  1  one-cycle launch pulse to sender; registered.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky: a push was dropped.
- `busy`  out  1  FSM not in S_IDLE.
- `tx_done`  out  1  one-cycle pulse when a launched frame completes.

## Operation
- Storage: DEPTH×8 register array; `wr_ptr` and `rd_ptr` are AW bits and wrap modulo DEPTH. `count` is a separate AW+1 counter; `empty` and `full` are decoded from `count` only.
- Push: when `wr_en` is high and (`!full` or a pop occurs in the same cycle), write `wr_data` at `wr_ptr` and increment `wr_ptr`.
- Dropped push: when `wr_en` is high, `full` is high and no pop occurs that cycle, the byte is discarded and `overflow` is set to 1.
- `overflow` clears only on `clr_ovf` or reset. If set and clear occur in the same cycle, set wins.
- `count` next value: +1 on accepted push only; −1 on pop only; unchanged on push+pop or on neither.
- FSM states:
  - S_IDLE: if `!empty && tx_status`, register `tx_data <= mem[rd_ptr]`, `tx_en <= 1`, increment `rd_ptr` (this is the pop), go to S_ARM. Otherwise stay.
  - S_ARM: `tx_en <= 0`. If `tx_status == 0`, go to S_SEND; else stay. The sender drops `tx_status` one cycle after sampling `tx_en`.
  - S_SEND: if `tx_status == 1`, pulse `tx_done`, go to S_IDLE; else stay.
- `tx_data` holds its value from launch until the next launch. The sender latches it, so holding is not required, but the value must not glitch.
- A write into an empty FIFO during S_IDLE is never launched in the same cycle; the pop uses registered state.

## Timing
- Reset (`reset == 0` at an edge): `wr_ptr = rd_ptr = 0`, `count = 0`, `tx_data = 0`, `tx_en = 0`, `overflow = 0`, `tx_done = 0`, FSM = S_IDLE. Derived outputs: `empty = 1`, `full = 0`, `busy = 0`. Array contents are not reset.
- Reset mid-frame returns to S_IDLE immediately and discards queued bytes. Resetting the sender with the same signal is the integrator's responsibility.
- Latency, sender idle: push sampled at edge N → `count = 1` after N → `tx_en` high for exactly the cycle after edge N+1, with `count` back to 0.
- Inter-frame gap: after `tx_status` rises at edge M, `tx_done` is high after M and the next `tx_en` is high after M+1. Minimum one idle cycle between frames.
- `tx_en` never asserts while `tx_status == 0`, and never for two consecutive cycles.
- Push and pop in the same cycle when `full`: both succeed, `count` stays DEPTH, `overflow` unchanged.

## Test plan
- Reset, then idle 10 cycles → `empty = 1`, `count = 0`, `tx_en` never high, `busy = 0`.
- Push 0xA5 with the sender model idle (its `tx_status` drops 1 cycle after `tx_en` and rises 20 cycles later) → one `tx_en` pulse 2 edges after the push with `tx_data = 0xA5`; `tx_done` 1 cycle after `tx_status` rises; `busy` returns to 0.
- Push 0x01..0x10 on 16 consecutive cycles (DEPTH = 16) → no overflow. Sender receives 0x01..0x10 in order with 16 `tx_done` pulses; pointers wrap and `count` ends at 0.
- Hold the sender busy; push 17 bytes → `full = 1` after 16 pushes, the 17th is dropped, `overflow = 1`. `clr_ovf` clears it; `clr_ovf` asserted together with another dropped push leaves `overflow = 1`.
- With `full = 1` and the FSM in S_IDLE, push 0x77 in the launch cycle → push accepted, `count` stays 16, 0x77 is sent last.
- Assert reset while in S_SEND with 5 bytes queued → next cycle `count = 0`, `busy = 0`, `tx_en = 0`; no further launches after the sender returns idle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding the UART bit serializer.
// Bytes queue from the bus side. One byte is launched per frame, and only
// while the sender reports idle. Each frame is tracked until the sender
// returns to idle.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  input  logic          tx_status,
  output logic [7:0]    tx_data,
  output logic          tx_en,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          busy,
  output logic          tx_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_SEND
  } state_e;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic          ovf_q, ovf_d;
  logic          tx_done_q, tx_done_d;
  logic          pop, push;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign tx_data  = tx_data_q;
  assign tx_en    = tx_en_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != S_IDLE);
  assign tx_done  = tx_done_q;

  // Launch sequencer: pops and launches from IDLE, waits for the sender to go busy, then waits for it to finish.
  always_comb begin
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_done_d = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && tx_status) begin
          pop       = 1'b1;
          tx_en_d   = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        if (!tx_status) state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_status) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: a pop in the same cycle frees room for a push even when full.
  always_comb begin
    push     = wr_en && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    ovf_d = ovf_q;
    if (clr_ovf)        ovf_d = 1'b0;
    if (wr_en && !push) ovf_d = 1'b1;
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      ovf_q     <= ovf_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural sender model.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int SEND_CYC = 20;

  logic          sysclk  = 1'b0;
  logic          reset   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          clr_ovf = 1'b0;
  logic          tx_status;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic [AW:0]   count;
  logic          empty, full, overflow, busy, tx_done;

  int checks = 0;
  int errors = 0;

  // Sender model state; hold forces the sender to look busy.
  logic        model_idle = 1'b1;
  logic        hold       = 1'b0;
  logic        prev_en    = 1'b0;
  int unsigned rem        = 0;
  int unsigned launches   = 0;
  int unsigned dones      = 0;
  logic [7:0]  exp_q [$];

  assign tx_status = model_idle && !hold;

  always #5 sysclk = ~sysclk;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .tx_status (tx_status),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  // Sender model: samples tx_en at the edge, goes busy just after it, idles again SEND_CYC cycles later.
  always @(posedge sysclk) begin
    logic       en_s, st_s, done_s;
    logic [7:0] d_s;
    en_s   = (tx_en === 1'b1);
    st_s   = tx_status;
    done_s = (tx_done === 1'b1);
    d_s    = tx_data;
    #1;
    if (done_s) dones++;
    if (en_s) begin
      launches++;
      chk("tx_en_while_status_low", {31'd0, st_s}, 32'd1);
      chk("tx_en_back_to_back", {31'd0, prev_en}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch: got tx_data 0x%0h, expected no launch", d_s);
      end else begin
        chk("tx_data_order", {24'd0, d_s}, {24'd0, exp_q.pop_front()});
      end
      model_idle = 1'b0;
      rem        = SEND_CYC;
    end else if (!model_idle) begin
      rem--;
      if (rem == 0) model_idle = 1'b1;
    end
    prev_en = en_s;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        wr;
    logic [7:0]  d;
    logic        clr;
    logic        acc;
    logic [AW:0] cnt;
    logic        ful;
    logic        ovf;
  } vec_t;

  vec_t        vt [21];
  int          n;
  int unsigned base;

  initial begin
    // Fill/overflow table, applied with the sender held busy.
    for (int i = 0; i < 16; i++)
      vt[i] = '{1'b1, 8'(8'h10 + i), 1'b0, 1'b1, (AW+1)'(i + 1), (i == 15), 1'b0};
    vt[16] = '{1'b1, 8'hEE, 1'b0, 1'b0, 5'd16, 1'b1, 1'b1}; // dropped push
    vt[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0}; // clear
    vt[18] = '{1'b1, 8'hEF, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1}; // set beats clear
    vt[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd16, 1'b1, 1'b1}; // sticky
    vt[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0}; // clear

    // Reset state
    reset = 1'b0;
    @(negedge sysclk);
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_data", tx_data, 0);
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_tx_en", tx_en, 0);
      chk("idle_count", count, 0);
      chk("idle_empty", empty, 1);
      chk("idle_busy", busy, 0);
    end

    // Single byte latency and frame tracking
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    chk("a5_count_after_push", count, 1);
    chk("a5_no_early_en", tx_en, 0);
    tick();
    chk("a5_tx_en", tx_en, 1);
    chk("a5_tx_data", tx_data, 8'hA5);
    chk("a5_count_after_pop", count, 0);
    chk("a5_busy", busy, 1);
    tick();
    chk("a5_tx_en_single", tx_en, 0);
    n = 0;
    while (!tx_status && n < 100) begin tick(); n++; end
    chk("a5_status_timeout", {31'd0, n < 100}, 1);
    chk("a5_no_done_yet", tx_done, 0);
    tick();
    chk("a5_tx_done", tx_done, 1);
    chk("a5_busy_clear", busy, 0);
    tick();
    chk("a5_tx_done_pulse", tx_done, 0);

    // Sixteen back-to-back pushes with the sender idle
    base = dones;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      tick();
    end
    wr_en = 1'b0;
    chk("burst_no_overflow", overflow, 0);
    chk("burst_count", count, 15);
    n = 0;
    while ((dones != base + 16 || count != 0 || busy) && n < 1000) begin tick(); n++; end
    chk("burst_drain_timeout", {31'd0, n < 1000}, 1);
    chk("burst_done_pulses", dones - base, 16);
    chk("burst_count_end", count, 0);
    chk("burst_queue_empty", exp_q.size(), 0);

    // Fill and overflow table
    hold = 1'b1;
    for (int i = 0; i < 21; i++) begin
      wr_en = vt[i].wr; wr_data = vt[i].d; clr_ovf = vt[i].clr;
      if (vt[i].acc) exp_q.push_back(vt[i].d);
      tick();
      chk($sformatf("vec%0d_count", i), count, vt[i].cnt);
      chk($sformatf("vec%0d_full", i), full, vt[i].ful);
      chk($sformatf("vec%0d_empty", i), empty, vt[i].cnt == 0);
      chk($sformatf("vec%0d_overflow", i), overflow, vt[i].ovf);
      chk($sformatf("vec%0d_tx_en", i), tx_en, 0);
    end
    wr_en = 1'b0; clr_ovf = 1'b0;

    // Push into a full FIFO in the launch cycle
    base  = dones;
    hold  = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77; exp_q.push_back(8'h77);
    tick();
    wr_en = 1'b0;
    chk("launch_push_count", count, 16);
    chk("launch_push_full", full, 1);
    chk("launch_push_tx_en", tx_en, 1);
    chk("launch_push_tx_data", tx_data, 8'h10);
    chk("launch_push_overflow", overflow, 0);
    n = 0;
    while ((dones != base + 17 || count != 0 || busy) && n < 1000) begin tick(); n++; end
    chk("full_drain_timeout", {31'd0, n < 1000}, 1);
    chk("full_done_pulses", dones - base, 17);
    chk("full_queue_empty", exp_q.size(), 0);

    // Reset mid-frame with bytes queued
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + i); exp_q.push_back(8'(8'hC0 + i));
      tick();
    end
    wr_en = 1'b0;
    n = 0;
    while (tx_status && n < 20) begin tick(); n++; end
    tick();
    chk("pre_reset_count", count, 5);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_reset_count", count, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_tx_en", tx_en, 0);
    chk("mid_reset_empty", empty, 1);
    exp_q.delete();
    base = launches;
    n = 0;
    while (!tx_status && n < 100) begin tick(); n++; end
    repeat (10) tick();
    chk("post_reset_no_launch", launches, base);
    chk("post_reset_count", count, 0);
    chk("post_reset_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
